// File: rtl/fifo_rd_fwft.sv
// Read-side controller of the dual-clock FIFO: read pointers, empty flag,
// first-word-fall-through output register and read-side fill level.
module fifo_rd_fwft #(
    parameter int P_SIZE = 4,
    parameter int D_SIZE = 8
) (
    input  logic              r_clk,
    input  logic              r_rstn,
    input  logic [P_SIZE-1:0] sync_wr_ptr,
    input  logic [D_SIZE-1:0] mem_rdata,
    input  logic              r_ready,
    output logic [P_SIZE-2:0] r_addr,
    output logic [P_SIZE-1:0] gray_r_ptr,
    output logic [D_SIZE-1:0] r_data,
    output logic              r_valid,
    output logic              empty,
    output logic [P_SIZE-1:0] r_level
);

    logic [P_SIZE-1:0] r_ptr;
    logic [P_SIZE-1:0] r_ptr_next;
    logic [P_SIZE-1:0] wr_bin;
    logic              pop;

    assign r_addr     = r_ptr[P_SIZE-2:0];
    assign r_ptr_next = r_ptr + P_SIZE'(1);
    assign empty      = (gray_r_ptr == sync_wr_ptr);
    assign pop        = !empty && (!r_valid || r_ready);

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < P_SIZE; i++) begin
            wr_bin[i] = ^(sync_wr_ptr >> i);
        end
    end

    assign r_level = wr_bin - r_ptr;

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            r_ptr      <= '0;
            gray_r_ptr <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else if (pop) begin
            r_ptr      <= r_ptr_next;
            gray_r_ptr <= (r_ptr_next >> 1) ^ r_ptr_next;
            r_data     <= mem_rdata;
            r_valid    <= 1'b1;
        end else if (r_ready) begin
            r_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Directed self-checking bench for fifo_rd_fwft with a small memory model
// driven through a binary write pointer converted to Gray.
module tb_fifo_rd_fwft;

    localparam int P_SIZE = 4;
    localparam int D_SIZE = 8;

    logic              r_clk;
    logic              r_rstn;
    logic [P_SIZE-1:0] sync_wr_ptr;
    logic [D_SIZE-1:0] mem_rdata;
    logic              r_ready;
    logic [P_SIZE-2:0] r_addr;
    logic [P_SIZE-1:0] gray_r_ptr;
    logic [D_SIZE-1:0] r_data;
    logic              r_valid;
    logic              empty;
    logic [P_SIZE-1:0] r_level;

    logic [P_SIZE-1:0] wp;
    logic [D_SIZE-1:0] mem [8];

    int checks = 0;
    int errors = 0;

    assign sync_wr_ptr = wp ^ (wp >> 1);
    assign mem_rdata   = mem[r_addr];

    fifo_rd_fwft #(.P_SIZE(P_SIZE), .D_SIZE(D_SIZE)) dut (
        .r_clk      (r_clk),
        .r_rstn     (r_rstn),
        .sync_wr_ptr(sync_wr_ptr),
        .mem_rdata  (mem_rdata),
        .r_ready    (r_ready),
        .r_addr     (r_addr),
        .gray_r_ptr (gray_r_ptr),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .empty      (empty),
        .r_level    (r_level)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic rst_pulse();
        r_rstn = 1'b0;
        #2;
        r_rstn = 1'b1;
        #1;
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] prev_g;
    int n;
    logic [3:0] lvl_tab [8];

    initial begin
        wp      = '0;
        r_ready = 1'b0;
        r_rstn  = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #1;
        r_rstn = 1'b0;
        #2;
        chk("rst_valid", 32'(r_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_level", 32'(r_level), 32'h0);
        chk("rst_addr", 32'(r_addr), 32'h0);
        chk("rst_gray", 32'(gray_r_ptr), 32'h0);
        chk("rst_data", 32'(r_data), 32'h0);
        for (int i = 0; i < 3; i++) begin
            r_ready = ~r_ready;
            step();
            chk("rst_hold_valid", 32'(r_valid), 32'h0);
            chk("rst_hold_gray", 32'(gray_r_ptr), 32'h0);
            chk("rst_hold_empty", 32'(empty), 32'h1);
        end
        r_ready = 1'b0;
        r_rstn  = 1'b1;
        step();

        // first word fall-through
        mem[0] = 8'hA5;
        wp     = 4'd1;
        #1;
        chk("fwft_empty", 32'(empty), 32'h0);
        chk("fwft_level", 32'(r_level), 32'h1);
        chk("fwft_valid0", 32'(r_valid), 32'h0);
        step();
        chk("fwft_valid", 32'(r_valid), 32'h1);
        chk("fwft_data", 32'(r_data), 32'hA5);
        chk("fwft_gray", 32'(gray_r_ptr), 32'h1);
        chk("fwft_empty1", 32'(empty), 32'h1);
        chk("fwft_level0", 32'(r_level), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_data", 32'(r_data), 32'hA5);
            chk("stall_valid", 32'(r_valid), 32'h1);
        end
        r_ready = 1'b1;
        step();
        chk("drain_valid", 32'(r_valid), 32'h0);
        chk("drain_data", 32'(r_data), 32'hA5);

        // preload eight words from a fresh reset
        r_ready = 1'b0;
        wp      = '0;
        rst_pulse();
        chk("re_rst_addr", 32'(r_addr), 32'h0);
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        wp = 4'd8;
        #1;
        chk("full_level", 32'(r_level), 32'h8);
        chk("full_wrgray", 32'(sync_wr_ptr), 32'hC);
        r_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("burst_addr", 32'(r_addr), 32'(i));
            step();
            chk("burst_valid", 32'(r_valid), 32'h1);
            chk("burst_data", 32'(r_data), 32'(8'h10 + i));
        end
        chk("burst_gray", 32'(gray_r_ptr), 32'hC);
        chk("burst_empty", 32'(empty), 32'h1);
        chk("burst_addr_end", 32'(r_addr), 32'h0);
        step();
        chk("burst_idle", 32'(r_valid), 32'h0);

        // 20 words streamed through the pointer wrap
        for (int k = 0; k < 20; k++) begin
            prev_g = gray_r_ptr;
            mem[wp[2:0]] = 8'(8'h40 + k);
            wp = wp + 4'd1;
            step();
            chk("wrap_valid", 32'(r_valid), 32'h1);
            chk("wrap_data", 32'(r_data), 32'(8'h40 + k));
            chk("wrap_gray", 32'(gray_r_ptr), 32'(gray4(4'(8 + k + 1))));
            chk("wrap_onebit", 32'($countones(gray_r_ptr ^ prev_g)), 32'h1);
        end
        step();
        chk("wrap_idle", 32'(r_valid), 32'h0);
        chk("wrap_ptr", 32'(r_addr), 32'h4);

        // alternating backpressure with four words queued
        for (int i = 0; i < 4; i++) mem[4 + i] = 8'(8'h80 + i);
        wp = wp + 4'd4;
        lvl_tab = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
        n = 0;
        for (int i = 0; i < 8; i++) begin
            r_ready = i[0];
            #1;
            if (r_valid && r_ready) begin
                chk("bp_data", 32'(r_data), 32'(8'h80 + n));
                n++;
            end
            step();
            chk("bp_level", 32'(r_level), 32'(lvl_tab[i]));
        end
        chk("bp_count", 32'(n), 32'h4);
        chk("bp_valid_end", 32'(r_valid), 32'h0);

        // asynchronous reset mid-stream
        r_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[wp[2:0] + 3'(i)] = 8'(8'hC0 + i);
        wp = wp + 4'd4;
        step();
        chk("mid_valid", 32'(r_valid), 32'h1);
        chk("mid_level", 32'(r_level), 32'h3);
        #2;
        r_rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(r_valid), 32'h0);
        chk("arst_addr", 32'(r_addr), 32'h0);
        chk("arst_gray", 32'(gray_r_ptr), 32'h0);
        chk("arst_data", 32'(r_data), 32'h0);
        r_rstn = 1'b1;
        #1;
        chk("post_empty", 32'(empty), 32'h0);
        chk("post_level", 32'(r_level), 32'h4);
        step();
        chk("post_valid", 32'(r_valid), 32'h1);
        chk("post_data", 32'(r_data), 32'hC0);
        wp = 4'd1;
        #1;
        chk("post_empty1", 32'(empty), 32'h1);
        chk("post_level0", 32'(r_level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
Read-side controller for the dual-clock async FIFO. It runs entirely in the read clock domain. It owns the binary and Gray read pointers and generates the empty flag from the already-synchronised Gray write pointer. A first-word-fall-through output register with a valid/ready handshake presents data to the consumer, and the block also reports the memory fill level seen from the read side.

Parameters:
P_SIZE, 4, pointer width including wrap bit; memory depth = 2^(P_SIZE-1)
D_SIZE, 8, data word width

Ports:
r_clk  input  1  read-domain clock, all flops on rising edge
r_rstn  input  1  asynchronous active-low reset
sync_wr_ptr  input  P_SIZE  Gray write pointer, already 2-flop synchronised into r_clk
mem_rdata  input  D_SIZE  FIFO memory read data; combinational function of r_addr
r_ready  input  1  consumer accepts r_data this cycle
r_addr  output  P_SIZE-1  memory read address = r_ptr[P_SIZE-2:0]
gray_r_ptr  output  P_SIZE  registered Gray read pointer, sent to write domain synchroniser
r_data  output  D_SIZE  registered output word
r_valid  output  1  r_data holds a valid word
empty  output  1  no unread word in memory (output register excluded)
r_level  output  P_SIZE  words in memory not yet popped, 0..2^(P_SIZE-1)

Behaviour:
- Reset (async, r_rstn=0): r_ptr=0, gray_r_ptr=0, r_data=0, r_valid=0. empty=1 and r_level=0 provided sync_wr_ptr=0.
- Reset mid-operation: the block returns to the reset state immediately. Any in-flight word in the output register is discarded.
- empty = (gray_r_ptr == sync_wr_ptr). This is combinational from registered gray_r_ptr.
- gray_r_ptr is always Gray(r_ptr).
  - Both registers update on the same edge: gray_r_ptr <= (r_ptr_next>>1)^r_ptr_next.
  - gray_r_ptr has zero lag relative to r_ptr, and only one bit changes per pop.
- pop = !empty && (!r_valid || r_ready).
- On pop:
  - r_data <= mem_rdata at current r_addr.
  - r_ptr <= r_ptr+1, mod 2^P_SIZE. Wrap is natural overflow, and the MSB toggles on each memory lap.
  - r_valid <= 1.
- No pop and r_valid && r_ready: r_valid <= 0; r_data holds its value.
- No pop and !r_ready: r_data and r_valid hold.
  - r_data must not change while r_valid=1 and r_ready=0.
- Simultaneous r_valid && r_ready && !empty: the output word is consumed and the next word is loaded on the same edge. Throughput is 1 word/cycle, and r_valid stays 1.
- First-word-fall-through latency:
  - A word becomes visible once sync_wr_ptr changes so that empty=0.
  - r_valid rises on the next r_clk edge, so latency is 1 cycle from empty deasserting.
- The consumer can never underflow. r_ready while r_valid=0 has no effect.
- r_level = Bin(sync_wr_ptr) - r_ptr, computed mod 2^P_SIZE.
  - Gray-to-binary conversion uses an XOR prefix from the MSB: b[i] = ^g[P_SIZE-1:i].
  - Output is combinational.
  - r_level = 0 exactly when empty = 1.
  - Maximum value is 2^(P_SIZE-1); in that case the MSBs differ and all lower bits are equal.
- sync_wr_ptr is treated as already stable. The block adds no synchroniser of its own.
- Nothing is sticky: there are no error flags, and empty/r_level track sync_wr_ptr every cycle.

Test Plan:
- Reset with sync_wr_ptr=0 -> r_valid=0, empty=1, r_level=0, r_addr=0, gray_r_ptr=0000; hold r_rstn=0 for 3 cycles while toggling r_ready -> all outputs stay at reset values.
- P_SIZE=4. Step sync_wr_ptr 0000->0001 with mem_rdata=0xA5 at addr 0 and r_ready=0:
  - empty falls, and r_level=1 in the same cycle.
  - Next edge: r_valid=1, r_data=0xA5, gray_r_ptr=0001, empty=1.
  - Hold r_ready=0 for 5 cycles -> r_data stays 0xA5.
- Preload 8 words (sync_wr_ptr=Gray(8)=1100) -> r_level=8. With r_ready=1 continuously:
  - Words appear on 8 consecutive cycles, with r_addr stepping 0..7.
  - Afterwards r_ptr=8, gray_r_ptr=1100, empty=1.
- Wrap: run 20 words through with sync_wr_ptr advancing in Gray steps -> r_ptr wraps 15->0, gray_r_ptr 1000->0000, data order is preserved, and exactly one bit of gray_r_ptr changes per pop.
- Backpressure: toggle r_ready 1/0 each cycle with 4 words queued -> each word is delivered exactly once, in order, with no duplicates; r_level decrements only on pop edges.
- Assert r_rstn low mid-stream with r_valid=1 and r_level=3 -> r_valid=0 and r_ptr=0 immediately, without waiting for a clock edge; after release, empty follows the current sync_wr_ptr.
